// File: rtl/idu_issue_sequencer.sv
// idu_issue_sequencer: issues {CMD, Operand_ID, DATA} words to the IDU array and
// turns INIT/CTS pseudo-ops into one-cycle pulses followed by a settle wait.
//
// Ports:
//   sys_clk, sys_resetb        clock (rising edge), async active-low reset
//   enable                     gates new accepts only
//   flush                      synchronous abort to IDLE
//   instr_valid/instr_ready    input handshake
//   instr_cmd/operand/data     instruction word
//   cmd_o/operand_o/data_o     registered IDU CMD, Operand_ID, DATA_i0
//   init_o, cts_o              one-cycle pulses to the IDU
//   busy                       high while not IDLE
//   issue_count                wrapping count of forwarded real opcodes
module idu_issue_sequencer #(
    parameter logic [3:0] OP_NOP    = 4'b0000,
    parameter logic [3:0] OP_INIT   = 4'b0001,
    parameter logic [3:0] OP_CTS    = 4'b0010,
    parameter int         INIT_WAIT = 17,
    parameter int         CTS_WAIT  = 17
) (
    input  logic        sys_clk,
    input  logic        sys_resetb,
    input  logic        enable,
    input  logic        flush,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  instr_cmd,
    input  logic [7:0]  instr_operand,
    input  logic [47:0] instr_data,
    output logic [3:0]  cmd_o,
    output logic [7:0]  operand_o,
    output logic [47:0] data_o,
    output logic        init_o,
    output logic        cts_o,
    output logic        busy,
    output logic [15:0] issue_count
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    // The counter is loaded one below the wait length: the pulse cycle itself
    // is the first non-accepting cycle, and the counter==0 cycle is the last.
    localparam logic [4:0] INIT_LOAD = 5'(INIT_WAIT - 1);
    localparam logic [4:0] CTS_LOAD  = 5'(CTS_WAIT - 1);

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_cmd, w_cmd_nxt;
    logic [7:0]  r_operand, w_operand_nxt;
    logic [47:0] r_data, w_data_nxt;
    logic        r_init, w_init_nxt;
    logic        r_cts, w_cts_nxt;
    logic [15:0] r_count, w_count_nxt;
    logic        w_accept, w_is_init, w_is_cts, w_is_real;

    assign instr_ready = enable & ~flush & (r_state != S_WAIT);
    assign w_accept    = instr_valid & instr_ready;
    assign w_is_init   = instr_cmd == OP_INIT;
    assign w_is_cts    = instr_cmd == OP_CTS;
    assign w_is_real   = w_accept & ~w_is_init & ~w_is_cts;

    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cmd     <= OP_NOP;
            r_operand <= '0;
            r_data    <= '0;
            r_init    <= 1'b0;
            r_cts     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cmd     <= w_cmd_nxt;
            r_operand <= w_operand_nxt;
            r_data    <= w_data_nxt;
            r_init    <= w_init_nxt;
            r_cts     <= w_cts_nxt;
            r_count   <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_is_real ? S_ISSUE : S_WAIT;
            w_cnt_nxt   = w_is_init ? INIT_LOAD : w_is_cts ? CTS_LOAD : 5'd0;
        end else if (r_state == S_WAIT) begin
            w_state_nxt = (r_cnt == 5'd0) ? S_IDLE : S_WAIT;
            w_cnt_nxt   = (r_cnt == 5'd0) ? 5'd0 : r_cnt - 5'd1;
        end
    end

    // flush forces instr_ready low, so w_accept already covers the flush case.
    always_comb begin
        w_cmd_nxt     = w_is_real ? instr_cmd : OP_NOP;
        w_operand_nxt = w_is_real ? instr_operand : r_operand;
        w_data_nxt    = w_is_real ? instr_data : r_data;
        w_init_nxt    = w_accept & w_is_init;
        w_cts_nxt     = w_accept & w_is_cts;
        w_count_nxt   = r_count + {15'd0, w_is_real};
    end

    assign cmd_o       = r_cmd;
    assign operand_o   = r_operand;
    assign data_o      = r_data;
    assign init_o      = r_init;
    assign cts_o       = r_cts;
    assign busy        = r_state != S_IDLE;
    assign issue_count = r_count;
endmodule

// File: tb/tb_idu_issue_sequencer.sv
// tb_idu_issue_sequencer: vector table, corner sequences and a random run against a reference model.
module tb_idu_issue_sequencer;
    localparam int IW = 17;
    localparam int CW = 17;

    logic        sys_clk = 1'b0;
    logic        sys_resetb = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic [3:0]  instr_cmd = '0;
    logic [7:0]  instr_operand = '0;
    logic [47:0] instr_data = '0;
    logic        instr_ready;
    logic [3:0]  cmd_o;
    logic [7:0]  operand_o;
    logic [47:0] data_o;
    logic        init_o;
    logic        cts_o;
    logic        busy;
    logic [15:0] issue_count;

    idu_issue_sequencer dut (
        .sys_clk(sys_clk), .sys_resetb(sys_resetb), .enable(enable), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_cmd(instr_cmd),
        .instr_operand(instr_operand), .instr_data(instr_data), .cmd_o(cmd_o),
        .operand_o(operand_o), .data_o(data_o), .init_o(init_o), .cts_o(cts_o),
        .busy(busy), .issue_count(issue_count)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic v, input logic [3:0] c,
                         input logic [7:0] o, input logic [47:0] d);
        enable = en; flush = fl; instr_valid = v;
        instr_cmd = c; instr_operand = o; instr_data = d;
    endtask

    typedef struct {
        logic en, fl, v;
        logic [3:0] cmd;
        logic [7:0] opd;
        logic [47:0] data;
        logic rdy;
        logic [3:0] ecmd;
        logic [7:0] eopd;
        logic [47:0] edata;
        logic einit, ects, ebusy;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[8];

    // reference model: "blocked" is the number of remaining non-accepting cycles
    logic [3:0]  m_cmd;
    logic [7:0]  m_opd;
    logic [47:0] m_data;
    logic        m_init, m_cts, m_issued;
    int          m_blocked;
    logic [15:0] m_cnt;

    initial begin
        tbl[0] = '{1,0,1,4'h8,8'hA5,48'h1234_5678_9ABC, 1, 4'h8,8'hA5,48'h1234_5678_9ABC, 0,0,1,16'd1};
        tbl[1] = '{1,0,1,4'hA,8'h08,48'h0000_0000_003C, 1, 4'hA,8'h08,48'h0000_0000_003C, 0,0,1,16'd2};
        tbl[2] = '{1,0,0,4'hB,8'h77,48'h0, 1, 4'h0,8'h08,48'h0000_0000_003C, 0,0,0,16'd2};
        tbl[3] = '{0,0,1,4'hB,8'h77,48'h0, 0, 4'h0,8'h08,48'h0000_0000_003C, 0,0,0,16'd2};
        tbl[4] = '{1,1,1,4'hB,8'h77,48'h0, 0, 4'h0,8'h08,48'h0000_0000_003C, 0,0,0,16'd2};
        tbl[5] = '{1,0,1,4'h0,8'h11,48'h55, 1, 4'h0,8'h11,48'h55, 0,0,1,16'd3};
        tbl[6] = '{1,0,1,4'h1,8'h22,48'h66, 1, 4'h0,8'h11,48'h55, 1,0,1,16'd3};
        tbl[7] = '{1,0,0,4'h0,8'h00,48'h0, 0, 4'h0,8'h11,48'h55, 0,0,1,16'd3};

        // reset and idle
        chk("rst_cmd", cmd_o, 0);
        repeat (3) tick();
        sys_resetb = 1'b1;
        enable = 1'b1;
        repeat (5) tick();
        chk("idle_cmd", cmd_o, 0);
        chk("idle_init", init_o, 0);
        chk("idle_cts", cts_o, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", instr_ready, 1);
        chk("idle_count", issue_count, 0);

        // table vectors
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].cmd, tbl[i].opd, tbl[i].data);
            #1;
            chk($sformatf("tbl%0d_ready", i), instr_ready, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d_cmd", i), cmd_o, tbl[i].ecmd);
            chk($sformatf("tbl%0d_opd", i), operand_o, tbl[i].eopd);
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].edata);
            chk($sformatf("tbl%0d_init", i), init_o, tbl[i].einit);
            chk($sformatf("tbl%0d_cts", i), cts_o, tbl[i].ects);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
            chk($sformatf("tbl%0d_count", i), issue_count, tbl[i].ecnt);
        end
        drive(1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("tbl_flush_busy", busy, 0);

        // INIT wait timing, then a Column issue right at ready
        drive(1, 0, 1, 4'h1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("init_pulse", init_o, 1);
        chk("init_ready_t1", instr_ready, 0);
        for (int k = 2; k <= IW; k++) begin
            tick();
            chk($sformatf("init_ready_t%0d", k), instr_ready, 0);
            if (k == 2) chk("init_pulse_off", init_o, 0);
        end
        tick();
        chk("init_ready_t18", instr_ready, 1);
        drive(1, 0, 1, 4'hB, 8'h3, 48'h9);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("col_cmd", cmd_o, 4'hB);
        chk("col_count", issue_count, 4);
        tick();
        chk("col_nop", cmd_o, 0);

        // CTS then flush 5 cycles later
        drive(1, 0, 1, 4'h2, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("cts_pulse", cts_o, 1);
        chk("cts_ready", instr_ready, 0);
        repeat (4) tick();
        chk("cts_nopulse", cts_o, 0);
        flush = 1'b1;
        #1;
        chk("flush_ready", instr_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_ready_after", instr_ready, 1);
        chk("flush_count", issue_count, 4);
        chk("flush_cmd", cmd_o, 0);

        // reset during WAIT with counter at 9
        drive(1, 0, 1, 4'h1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        repeat (7) tick();
        chk("rw_ready", instr_ready, 0);
        #2 sys_resetb = 1'b0;
        #1;
        chk("rw_cmd", cmd_o, 0);
        chk("rw_busy", busy, 0);
        chk("rw_count", issue_count, 0);
        chk("rw_opd", operand_o, 0);
        chk("rw_data", data_o, 0);
        chk("rw_init", init_o, 0);
        #1 sys_resetb = 1'b1;
        #1;
        chk("rw_ready_rel", instr_ready, 1);
        tick();
        chk("rw_busy_rel", busy, 0);

        // wrap of issue_count
        drive(1, 0, 1, 4'h8, 8'hA5, 48'h1);
        repeat (65535) tick();
        chk("wrap_ffff", issue_count, 16'hFFFF);
        chk("wrap_ready", instr_ready, 1);
        tick();
        chk("wrap_zero", issue_count, 0);
        chk("wrap_cmd", cmd_o, 4'h8);
        drive(1, 0, 0, 0, 0, 0);
        tick();

        // random run against the reference model
        sys_resetb = 1'b0;
        tick();
        sys_resetb = 1'b1;
        m_cmd = 0; m_opd = 0; m_data = 0; m_init = 0; m_cts = 0;
        m_issued = 0; m_blocked = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            logic en, fl, v, rdy, acc, real_op;
            logic [3:0] c;
            int r;
            en = ($urandom % 8) != 0;
            fl = ($urandom % 32) == 0;
            v  = ($urandom % 4) != 0;
            r  = $urandom % 16;
            c  = (r == 0) ? 4'h1 : (r == 1) ? 4'h2 : 4'($urandom);
            drive(en, fl, v, c, 8'($urandom), {16'($urandom), 32'($urandom)});
            #1;
            rdy = en && !fl && m_blocked == 0;
            chk("rnd_ready", instr_ready, rdy);
            acc = v && rdy;
            real_op = acc && c != 4'h1 && c != 4'h2;
            m_init = acc && c == 4'h1;
            m_cts  = acc && c == 4'h2;
            m_cmd  = real_op ? c : 4'h0;
            if (real_op) begin
                m_opd = instr_operand;
                m_data = instr_data;
                m_cnt = m_cnt + 1;
            end
            if (fl) m_blocked = 0;
            else if (m_init) m_blocked = IW;
            else if (m_cts) m_blocked = CW;
            else if (m_blocked > 0) m_blocked--;
            m_issued = real_op;
            tick();
            chk("rnd_cmd", cmd_o, m_cmd);
            chk("rnd_opd", operand_o, m_opd);
            chk("rnd_data", data_o, m_data);
            chk("rnd_init", init_o, m_init);
            chk("rnd_cts", cts_o, m_cts);
            chk("rnd_busy", busy, m_blocked > 0 || m_issued);
            chk("rnd_count", issue_count, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
